// File: rtl/id_stage_hazard_pipe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | id_stage_pkg : opcodes, control-word layout and decode helpers for the     |
// |                MIPS ID stage.                                              |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
package id_stage_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam int CTRL_W          = 9;
  localparam int CTRL_REG_DST    = 8;
  localparam int CTRL_ALU_SRC    = 7;
  localparam int CTRL_MEM_TO_REG = 6;
  localparam int CTRL_REG_WRITE  = 5;
  localparam int CTRL_MEM_READ   = 4;
  localparam int CTRL_MEM_WRITE  = 3;
  localparam int CTRL_BRANCH     = 2;
  localparam int CTRL_ALU_OP_MSB = 1;
  localparam int CTRL_ALU_OP_LSB = 0;

  localparam logic [CTRL_W-1:0] CTRL_RTYPE = 9'b100100010;
  localparam logic [CTRL_W-1:0] CTRL_LW    = 9'b011110000;
  localparam logic [CTRL_W-1:0] CTRL_SW    = 9'b010001000;
  localparam logic [CTRL_W-1:0] CTRL_BEQ   = 9'b000000101;
  localparam logic [CTRL_W-1:0] CTRL_NOP   = 9'b000000000;

  typedef enum logic [2:0] {
    INSTR_NOP   = 3'd0,
    INSTR_RTYPE = 3'd1,
    INSTR_LW    = 3'd2,
    INSTR_SW    = 3'd3,
    INSTR_BEQ   = 3'd4
  } instr_class_e;

  function automatic instr_class_e classify(input logic [5:0] op);
    case (op)
      OP_RTYPE: return INSTR_RTYPE;
      OP_LW:    return INSTR_LW;
      OP_SW:    return INSTR_SW;
      OP_BEQ:   return INSTR_BEQ;
      default:  return INSTR_NOP;
    endcase
  endfunction

  function automatic logic [CTRL_W-1:0] ctrl_of(input instr_class_e cls);
    case (cls)
      INSTR_RTYPE: return CTRL_RTYPE;
      INSTR_LW:    return CTRL_LW;
      INSTR_SW:    return CTRL_SW;
      INSTR_BEQ:   return CTRL_BEQ;
      default:     return CTRL_NOP;
    endcase
  endfunction

  // lw only consumes rs; its rt is a destination and cannot cause a load-use hazard
  function automatic logic reads_rt(input instr_class_e cls);
    return (cls == INSTR_RTYPE) || (cls == INSTR_SW) || (cls == INSTR_BEQ);
  endfunction

endpackage
`default_nettype wire

// File: rtl/id_stage_hazard_pipe_regfile.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | id_regfile : 2-read / 1-write register file, R0 hard-wired to zero.        |
// |              Macro ID_WB_BYPASS_EN forwards same-cycle writeback to reads. |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+
module id_regfile #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  localparam int RA_W    = $clog2(NUM_REGS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   we_i,
  input  logic [RA_W-1:0]        waddr_i,
  input  logic [DATA_W-1:0]      wdata_i,
  input  logic [1:0][RA_W-1:0]   raddr_i,
  output logic [1:0][DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [NUM_REGS];
  logic              w_wr_en;

  assign w_wr_en = we_i && (waddr_i != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (w_wr_en) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_rport
    logic [DATA_W-1:0] w_mem_rd;

    assign w_mem_rd = (raddr_i[p] == '0) ? '0 : mem_q[raddr_i[p]];

`ifdef ID_WB_BYPASS_EN
    assign rdata_o[p] = (w_wr_en && (waddr_i == raddr_i[p])) ? wdata_i : w_mem_rd;
`else
    assign rdata_o[p] = w_mem_rd;
`endif
  end

endmodule
`default_nettype wire

// File: rtl/id_stage_hazard_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | id_stage_hazard_pipe : MIPS decode stage with load-use stall, EX flush,    |
// |                        ID/EX register and saturating stall counter.        |
// |                        Optional macro: ID_WB_BYPASS_EN (in id_regfile).    |
// | Revision             : 1.0                                                 |
// +----------------------------------------------------------------------------+
module id_stage_hazard_pipe
  import id_stage_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int CNT_W    = 16,
  localparam int RA_W    = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_valid,
  input  logic [31:0]       if_instr,
  input  logic [ADDR_W-1:0] if_npc,
  input  logic              wb_reg_write,
  input  logic [RA_W-1:0]   wb_write_reg,
  input  logic [DATA_W-1:0] wb_write_data,
  input  logic              ex_flush,
  output logic              id_stall,
  output logic              idex_valid,
  output logic [8:0]        idex_ctrl,
  output logic [ADDR_W-1:0] idex_npc,
  output logic [DATA_W-1:0] idex_rs_data,
  output logic [DATA_W-1:0] idex_rt_data,
  output logic [DATA_W-1:0] idex_sign_ext,
  output logic [4:0]        idex_rs,
  output logic [4:0]        idex_rt,
  output logic [4:0]        idex_rd,
  output logic [CNT_W-1:0]  stall_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [5:0]              w_op;
  logic [4:0]              w_rs;
  logic [4:0]              w_rt;
  logic [4:0]              w_rd;
  instr_class_e            w_cls;
  logic [CTRL_W-1:0]       w_ctrl;
  logic [DATA_W-1:0]       w_sign_ext;
  logic [1:0][DATA_W-1:0]  w_rdata;
  logic                    w_hazard;
  logic                    w_load;

  logic                    idex_valid_q,    idex_valid_d;
  logic [CTRL_W-1:0]       idex_ctrl_q,     idex_ctrl_d;
  logic [ADDR_W-1:0]       idex_npc_q,      idex_npc_d;
  logic [DATA_W-1:0]       idex_rs_data_q,  idex_rs_data_d;
  logic [DATA_W-1:0]       idex_rt_data_q,  idex_rt_data_d;
  logic [DATA_W-1:0]       idex_sign_ext_q, idex_sign_ext_d;
  logic [4:0]              idex_rs_q,       idex_rs_d;
  logic [4:0]              idex_rt_q,       idex_rt_d;
  logic [4:0]              idex_rd_q,       idex_rd_d;
  logic [CNT_W-1:0]        stall_cnt_q,     stall_cnt_d;

  assign w_op       = if_instr[31:26];
  assign w_rs       = if_instr[25:21];
  assign w_rt       = if_instr[20:16];
  assign w_rd       = if_instr[15:11];
  assign w_cls      = classify(w_op);
  assign w_ctrl     = ctrl_of(w_cls);
  assign w_sign_ext = {{(DATA_W-16){if_instr[15]}}, if_instr[15:0]};

  id_regfile #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (wb_reg_write),
    .waddr_i (wb_write_reg),
    .wdata_i (wb_write_data),
    .raddr_i ({w_rt[RA_W-1:0], w_rs[RA_W-1:0]}),
    .rdata_o (w_rdata)
  );

  // The load sitting in ID/EX delivers its data too late for the instruction in ID
  assign w_hazard = idex_valid_q
                  && idex_ctrl_q[CTRL_MEM_READ]
                  && (idex_rt_q != 5'd0)
                  && ((idex_rt_q == w_rs) || ((idex_rt_q == w_rt) && reads_rt(w_cls)));

  assign id_stall = rst_n && if_valid && w_hazard && !ex_flush;
  assign w_load   = if_valid && !ex_flush && !id_stall;

  always_comb begin
    idex_valid_d    = 1'b0;
    idex_ctrl_d     = CTRL_NOP;
    idex_npc_d      = '0;
    idex_rs_data_d  = '0;
    idex_rt_data_d  = '0;
    idex_sign_ext_d = '0;
    idex_rs_d       = '0;
    idex_rt_d       = '0;
    idex_rd_d       = '0;
    if (w_load) begin
      idex_valid_d    = 1'b1;
      idex_ctrl_d     = w_ctrl;
      idex_npc_d      = if_npc;
      idex_rs_data_d  = w_rdata[0];
      idex_rt_data_d  = w_rdata[1];
      idex_sign_ext_d = w_sign_ext;
      idex_rs_d       = w_rs;
      idex_rt_d       = w_rt;
      idex_rd_d       = w_rd;
    end
  end

  assign stall_cnt_d = (id_stall && (stall_cnt_q != CNT_MAX)) ? stall_cnt_q + CNT_W'(1)
                                                              : stall_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idex_valid_q    <= 1'b0;
      idex_ctrl_q     <= CTRL_NOP;
      idex_npc_q      <= '0;
      idex_rs_data_q  <= '0;
      idex_rt_data_q  <= '0;
      idex_sign_ext_q <= '0;
      idex_rs_q       <= '0;
      idex_rt_q       <= '0;
      idex_rd_q       <= '0;
      stall_cnt_q     <= '0;
    end else begin
      idex_valid_q    <= idex_valid_d;
      idex_ctrl_q     <= idex_ctrl_d;
      idex_npc_q      <= idex_npc_d;
      idex_rs_data_q  <= idex_rs_data_d;
      idex_rt_data_q  <= idex_rt_data_d;
      idex_sign_ext_q <= idex_sign_ext_d;
      idex_rs_q       <= idex_rs_d;
      idex_rt_q       <= idex_rt_d;
      idex_rd_q       <= idex_rd_d;
      stall_cnt_q     <= stall_cnt_d;
    end
  end

  assign idex_valid    = idex_valid_q;
  assign idex_ctrl     = idex_ctrl_q;
  assign idex_npc      = idex_npc_q;
  assign idex_rs_data  = idex_rs_data_q;
  assign idex_rt_data  = idex_rt_data_q;
  assign idex_sign_ext = idex_sign_ext_q;
  assign idex_rs       = idex_rs_q;
  assign idex_rt       = idex_rt_q;
  assign idex_rd       = idex_rd_q;
  assign stall_count   = stall_cnt_q;

endmodule
`default_nettype wire
